matrix_input_loader: RTL and testbench

- Upstream feeder for the scalar-multiply stage.
- Accepts a dimension pair, then a serial stream of 8-bit elements in row-major order. Assembles them into the 5x5 packed 200-bit matrix format used by the arithmetic units: element (i,j) at bits [(i*5+j)*8 +: 8], with unused slots zero.
- Presents the matrix with its m/n and a held valid flag until the consumer acknowledges it.
- Rejects illegal dimensions and stalled input streams.

---
 rtl/matrix_input_loader.sv | 172 +++++++++++++++++
 tb/tb_matrix_input_loader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_input_loader.sv
// Serial-to-packed matrix loader: collects a row-major element stream into the
// 5x5 stride packed layout and holds it with its dimensions until acknowledged.
module matrix_input_loader #(
    parameter int MAX_DIM = 5,
    parameter int ELEM_W  = 8,
    parameter int TIMEOUT = 1000
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [2:0]                        dim_m,
    input  logic [2:0]                        dim_n,
    input  logic [ELEM_W-1:0]                 data_in,
    input  logic                              data_valid,
    input  logic                              abort,
    input  logic                              out_ack,
    output logic [MAX_DIM*MAX_DIM*ELEM_W-1:0] matrix,
    output logic [2:0]                        m_out,
    output logic [2:0]                        n_out,
    output logic                              matrix_valid,
    output logic                              busy,
    output logic                              error,
    output logic [4:0]                        elem_count
);

    localparam int MAT_W = MAX_DIM * MAX_DIM * ELEM_W;
    localparam int IDX_W = $clog2(MAT_W);
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE, ST_ERROR} state_t;

    state_t             state_r, state_s;
    logic [MAT_W-1:0]   matrix_r, matrix_s;
    logic [2:0]         m_r, m_s, n_r, n_s, row_r, row_s, col_r, col_s;
    logic               valid_r, valid_s, busy_r, busy_s, error_r, error_s;
    logic               last_r, last_s;
    logic [4:0]         count_r, count_s, slot_s;
    logic [TO_W-1:0]    to_r, to_s;
    logic [IDX_W-1:0]   base_s;
    logic               legal_s, last_elem_s;

    assign legal_s     = (dim_m >= 3'd1) && (dim_m <= 3'(MAX_DIM)) &&
                         (dim_n >= 3'd1) && (dim_n <= 3'(MAX_DIM));
    assign slot_s      = 5'(row_r) * 5'(MAX_DIM) + 5'(col_r);
    assign base_s      = IDX_W'(slot_s) * IDX_W'(ELEM_W);
    assign last_elem_s = (row_r == (m_r - 3'd1)) && (col_r == (n_r - 3'd1));

    // Next-state and next-output computation; last_r adds the one-cycle hold before DONE
    always_comb begin
        state_s  = state_r;
        matrix_s = matrix_r;
        m_s      = m_r;
        n_s      = n_r;
        valid_s  = valid_r;
        count_s  = count_r;
        row_s    = row_r;
        col_s    = col_r;
        to_s     = to_r;
        last_s   = last_r;
        if (start && (state_r != ST_LOAD)) begin
            valid_s = 1'b0;
            last_s  = 1'b0;
            if (legal_s) begin
                state_s  = ST_LOAD;
                m_s      = dim_m;
                n_s      = dim_n;
                matrix_s = {MAT_W{1'b0}};
                count_s  = 5'd0;
                row_s    = 3'd0;
                col_s    = 3'd0;
                to_s     = {TO_W{1'b0}};
            end else begin
                state_s = ST_ERROR;
            end
        end else begin
            case (state_r)
                ST_LOAD: begin
                    if (abort) begin
                        state_s  = ST_IDLE;
                        matrix_s = {MAT_W{1'b0}};
                        last_s   = 1'b0;
                    end else if (last_r) begin
                        state_s = ST_DONE;
                        valid_s = 1'b1;
                        last_s  = 1'b0;
                    end else if (data_valid) begin
                        matrix_s[base_s +: ELEM_W] = data_in;
                        count_s = count_r + 5'd1;
                        to_s    = {TO_W{1'b0}};
                        if (last_elem_s) begin
                            last_s = 1'b1;
                        end else if (col_r == (n_r - 3'd1)) begin
                            col_s = 3'd0;
                            row_s = row_r + 3'd1;
                        end else begin
                            col_s = col_r + 3'd1;
                        end
                    end else if ((TIMEOUT != 0) && (to_r == TO_W'(TIMEOUT - 1))) begin
                        state_s = ST_ERROR;
                    end else begin
                        to_s = to_r + TO_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ack) begin
                        state_s = ST_IDLE;
                        valid_s = 1'b0;
                    end else begin
                        valid_s = 1'b1;
                    end
                end
                ST_ERROR: begin
                    valid_s = 1'b0;
                    if (abort) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_ERROR;
                    end
                end
                ST_IDLE: begin
                    valid_s = 1'b0;
                end
                default: begin
                    state_s = ST_IDLE;
                    valid_s = 1'b0;
                end
            endcase
        end
        busy_s  = (state_s == ST_LOAD);
        error_s = (state_s == ST_ERROR);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            matrix_r <= {MAT_W{1'b0}};
            m_r      <= 3'd0;
            n_r      <= 3'd0;
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
            error_r  <= 1'b0;
            count_r  <= 5'd0;
            row_r    <= 3'd0;
            col_r    <= 3'd0;
            to_r     <= {TO_W{1'b0}};
            last_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            matrix_r <= matrix_s;
            m_r      <= m_s;
            n_r      <= n_s;
            valid_r  <= valid_s;
            busy_r   <= busy_s;
            error_r  <= error_s;
            count_r  <= count_s;
            row_r    <= row_s;
            col_r    <= col_s;
            to_r     <= to_s;
            last_r   <= last_s;
        end
    end

    assign matrix       = matrix_r;
    assign m_out        = m_r;
    assign n_out        = n_r;
    assign matrix_valid = valid_r;
    assign busy         = busy_r;
    assign error        = error_r;
    assign elem_count   = count_r;

endmodule

// File: tb/tb_matrix_input_loader.sv
// Scoreboard bench for matrix_input_loader: a driver streams loads and queues the
// expected matrix; a monitor compares whenever matrix_valid rises.
module tb_matrix_input_loader;

    logic         clk = 1'b0;
    logic         reset, start, data_valid, abort, out_ack;
    logic [2:0]   dim_m, dim_n, m_out, n_out;
    logic [7:0]   data_in;
    logic [199:0] matrix;
    logic         matrix_valid, busy, error;
    logic [4:0]   elem_count;

    typedef struct {
        logic [199:0] mat;
        logic [2:0]   m;
        logic [2:0]   n;
        logic [4:0]   cnt;
        int           cyc;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic prev_v = 1'b0;
    int   last_m = 0;
    int   last_n = 0;

    matrix_input_loader #(.MAX_DIM(5), .ELEM_W(8), .TIMEOUT(10)) dut (
        .clk(clk), .reset(reset), .start(start), .dim_m(dim_m), .dim_n(dim_n),
        .data_in(data_in), .data_valid(data_valid), .abort(abort), .out_ack(out_ack),
        .matrix(matrix), .m_out(m_out), .n_out(n_out), .matrix_valid(matrix_valid),
        .busy(busy), .error(error), .elem_count(elem_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference packing: element k of an m x n row-major stream lands at row k/n, col k%n
    function automatic logic [199:0] pack(input int m, input int n, input logic [7:0] q[$]);
        logic [199:0] p = 200'd0;
        for (int k = 0; k < m * n; k++) begin
            p = p | (200'(q[k]) << (((k / n) * 5 + (k % n)) * 8));
        end
        return p;
    endfunction

    // Monitor: on each rising matrix_valid pop and compare the oldest expectation
    always @(negedge clk) begin
        if (reset && matrix_valid && !prev_v) begin
            chk("sb_has_entry", 200'(sb_q.size() != 0), 200'd1);
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_matrix", matrix, e.mat);
                chk("sb_m_out", 200'(m_out), 200'(e.m));
                chk("sb_n_out", 200'(n_out), 200'(e.n));
                chk("sb_elem_count", 200'(elem_count), 200'(e.cnt));
                chk("sb_latency", 200'(cyc), 200'(e.cyc));
            end
        end
        prev_v <= matrix_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int m, input int n);
        dim_m = 3'(m);
        dim_n = 3'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        if (m >= 1 && m <= 5 && n >= 1 && n <= 5) begin
            last_m = m;
            last_n = n;
        end
    endtask

    // Streams m*n elements (sequential 1.. or random) with random gaps, queues expectation
    task automatic load(input int m, input int n, input int maxgap, input bit seq,
                        output logic [199:0] exp_mat);
        logic [7:0] elems[$];
        exp_t e;
        for (int k = 0; k < m * n; k++) begin
            int gaps = $urandom_range(maxgap, 0);
            for (int g = 0; g < gaps; g++) begin
                data_valid = 1'b0;
                tick();
            end
            data_in    = seq ? 8'(k + 1) : 8'($urandom_range(255, 0));
            data_valid = 1'b1;
            elems.push_back(data_in);
            tick();
        end
        data_valid = 1'b0;
        exp_mat = pack(m, n, elems);
        e.mat = exp_mat;
        e.m   = 3'(m);
        e.n   = 3'(n);
        e.cnt = 5'(m * n);
        e.cyc = cyc + 1;
        sb_q.push_back(e);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20 && !matrix_valid; i++) tick();
        chk("valid_wait", 200'(matrix_valid), 200'd1);
    endtask

    task automatic ack();
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        chk("ack_clears_valid", 200'(matrix_valid), 200'd0);
    endtask

    initial begin
        logic [199:0] em;
        reset = 1'b0; start = 1'b0; data_valid = 1'b0; abort = 1'b0; out_ack = 1'b0;
        dim_m = 3'd0; dim_n = 3'd0; data_in = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_matrix", matrix, 200'd0);
        chk("rst_flags", 200'({matrix_valid, busy, error}), 200'd0);
        chk("rst_dims_count", 200'({m_out, n_out, elem_count}), 200'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // 2x3 sequential elements with gaps
        do_start(2, 3);
        chk("load_busy", 200'(busy), 200'd1);
        load(2, 3, 2, 1'b1, em);
        wait_valid();
        chk("2x3_bytes", matrix, 200'h060504_0000_030201);
        chk("2x3_count", 200'(elem_count), 200'd6);
        ack();
        chk("2x3_retained", matrix, em);
        chk("idle_busy", 200'(busy), 200'd0);

        // 5x5 back-to-back, then a 26th element right behind the last
        do_start(5, 5);
        load(5, 5, 0, 1'b1, em);
        data_in = 8'hAA; data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        wait_valid();
        chk("5x5_byte24", 200'(8'(matrix >> 192)), 200'h19);
        chk("5x5_count_after_extra", 200'(elem_count), 200'd25);
        do_start(3, 2);
        chk("start_in_done_valid", 200'(matrix_valid), 200'd0);
        chk("start_in_done_busy", 200'(busy), 200'd1);
        chk("start_in_done_cleared", matrix, 200'd0);
        load(3, 2, 1, 1'b0, em);
        wait_valid();
        ack();

        // Illegal dimensions
        do_start(0, 3);
        chk("illegal_m_flags", 200'({error, busy, matrix_valid}), 200'b100);
        chk("illegal_m_dims", 200'({m_out, n_out}), 200'({3'(last_m), 3'(last_n)}));
        do_start(2, 2);
        chk("legal_clears_error", 200'({error, busy}), 200'b01);
        load(2, 2, 1, 1'b0, em);
        wait_valid();
        ack();
        do_start(2, 6);
        chk("illegal_n_flags", 200'({error, busy, matrix_valid}), 200'b100);
        chk("illegal_n_dims", 200'({m_out, n_out}), 200'({3'(last_m), 3'(last_n)}));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_in_error", 200'(error), 200'd0);

        // Randomized loads, occasionally with illegal dimensions
        for (int it = 0; it < 10; it++) begin
            int m, n;
            bit wild = ($urandom_range(3, 0) == 0);
            m = wild ? $urandom_range(7, 0) : $urandom_range(5, 1);
            n = wild ? $urandom_range(7, 0) : $urandom_range(5, 1);
            do_start(m, n);
            if (m >= 1 && m <= 5 && n >= 1 && n <= 5) begin
                load(m, n, 2, 1'b0, em);
                wait_valid();
                ack();
                chk("rand_retained", matrix, em);
            end else begin
                chk("rand_illegal_err", 200'(error), 200'd1);
                chk("rand_illegal_dims", 200'({m_out, n_out}), 200'({3'(last_m), 3'(last_n)}));
            end
        end

        // Timeout: one element of a 1x2 load, then silence
        do_start(1, 2);
        data_in = 8'h5A; data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        repeat (9) tick();
        chk("timeout_not_yet", 200'(error), 200'd0);
        tick();
        chk("timeout_error", 200'(error), 200'd1);
        chk("timeout_busy", 200'(busy), 200'd0);

        // Abort together with data_valid
        do_start(3, 3);
        data_in = 8'h11; data_valid = 1'b1;
        tick();
        data_in = 8'h22;
        tick();
        data_in = 8'h33; abort = 1'b1;
        tick();
        data_valid = 1'b0; abort = 1'b0;
        chk("abort_matrix", matrix, 200'd0);
        chk("abort_flags", 200'({busy, error, matrix_valid}), 200'd0);
        chk("abort_count", 200'(elem_count), 200'd2);
        tick();
        chk("abort_count_held", 200'(elem_count), 200'd2);

        // Asynchronous reset mid-load
        do_start(2, 3);
        for (int k = 0; k < 3; k++) begin
            data_in = 8'(k + 7); data_valid = 1'b1;
            tick();
        end
        data_valid = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        chk("async_rst_matrix", matrix, 200'd0);
        chk("async_rst_outs", 200'({m_out, n_out, elem_count, matrix_valid, busy, error}), 200'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        chk("sb_drained", 200'(sb_q.size()), 200'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
